des_buffer_arbiter: RTL and testbench
=====================================

Name: des_buffer_arbiter

Overview:
Controller for the single-address-port 64-bit output SRAM that holds 3DES ciphertext. It arbitrates each cycle between the DES output stream (producer) and the host CSR drain (consumer), and manages the SRAM as a ring buffer with wr/rd pointers, occupancy count and full/empty flags. It sits between the ECCDH3DES core output, the output sram instance and the Avalon slave CSR logic.

Parameters:
ADDRSIZE, 14, SRAM address width; buffer depth DEPTH = 2**ADDRSIZE words
SRAMWIDTH, 64, data word width
RD_LATENCY, 1, cycles from sram_re to valid sram_q (1..3)
AFULL_MARGIN, 4, almost_full asserts when count >= DEPTH-AFULL_MARGIN

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  sync clear of pointers/count, cancels in-flight reads
wr_valid  in  1  producer has a word
wr_data  in  SRAMWIDTH  producer word
wr_ready  out  1  write accepted this cycle
rd_req  in  1  consumer requests one word (held until rd_ack)
rd_ack  out  1  read request accepted this cycle
rd_valid  out  1  rd_data valid, one-cycle pulse
rd_data  out  SRAMWIDTH  returned word
sram_addr  out  ADDRSIZE  SRAM address (shared rd/wr)
sram_wdata  out  SRAMWIDTH  SRAM write data
sram_we  out  1  SRAM write enable
sram_re  out  1  SRAM read enable
sram_q  in  SRAMWIDTH  SRAM read data
count  out  ADDRSIZE+1  occupancy 0..DEPTH
full / empty / almost_full  out  1 each  status
watermark  in  ADDRSIZE+1  level-irq threshold (optional feature)
irq_clr  in  1  clears level_irq
level_irq  out  1  sticky watermark flag

Behaviour:
- Clock clk; reset async active-low on reset_n. Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, wr_ready=0, rd_ack=0, rd_valid=0, rd_data=0, last_grant=GNT_RD, read pipe cleared, level_irq=0.
- Eligibility: writer = wr_valid && !full; reader = rd_req && !empty.
- Grant (combinational, one per cycle): only one eligible -> it wins; both -> round-robin, winner is the one not equal to last_grant; none -> GNT_NONE. last_grant register updates only on a real grant.
- GNT_WR: wr_ready=1, sram_we=1, sram_addr=wr_ptr, sram_wdata=wr_data; wr_ptr+1, count+1.
- GNT_RD: rd_ack=1, sram_re=1, sram_addr=rd_ptr; rd_ptr+1, count-1; a token enters the RD_LATENCY-deep read pipe.
- GNT_NONE: sram_we=sram_re=0, sram_addr holds last value.
- sram_* and wr_ready/rd_ack are combinational from grant; pointers, count, flags registered.
- Read return: token exits pipe RD_LATENCY cycles after rd_ack; that cycle rd_valid=1, rd_data registered from sram_q, so rd_valid is seen RD_LATENCY+1 cycles after rd_ack. Back-to-back reads give back-to-back rd_valid.
- Pointers wrap modulo DEPTH (natural ADDRSIZE overflow). count never wraps: read and write cannot both occur in one cycle.
- full = (count==DEPTH); empty = (count==0). Write while full: wr_ready stays 0, data held by producer. rd_req while empty: rd_ack stays 0, request waits.
- flush: highest priority; no grant that cycle; next cycle pointers=0, count=0, empty=1; all pipe tokens dropped (no rd_valid for reads issued before flush). last_grant unchanged.
- Reset mid-operation: all state returns to reset values immediately; in-flight reads lost.

Optional Feature:
DESBUF_WATERMARK_EN
- Defined: level_irq sets when registered count >= watermark and watermark != 0; sticky until irq_clr; if both same cycle, set wins.
- Undefined: level_irq tied 0; watermark and irq_clr ignored; ports remain.

Decomposition:
- Package desbuf_pkg: grant_t enum {GNT_NONE, GNT_WR, GNT_RD}; DESBUF_MAX_RD_LATENCY=3.
- One sub-module desbuf_rd_pipe: RD_LATENCY-deep valid shift register with synchronous kill (flush).

Test Plan:
- ADDRSIZE=3: write 8 words 0x1..0x8 with rd_req=0 -> 8 wr_ready pulses, full=1, count=8; 9th wr_valid -> wr_ready stays 0.
- From full, rd_req held 8 cycles -> rd_data 0x1..0x8 in order, rd_valid RD_LATENCY+1 cycles after each rd_ack, empty=1 at end.
- wr_valid and rd_req both held with count=4 -> grants alternate WR,RD,WR,RD; count oscillates 5,4,5,4.
- 12 writes/reads interleaved over depth 8 -> pointers wrap, data 0x1..0xC returned intact.
- rd_ack at cycle t, flush at t+1 (RD_LATENCY=2) -> no rd_valid; count=0, empty=1 at t+2.
- DESBUF_WATERMARK_EN, watermark=5: 5th write -> level_irq=1; irq_clr with count=3 -> 0; without macro -> always 0.

Source files
------------

// File: rtl/desbuf_pkg.sv
`default_nettype none
//============================================================================
// Module   : desbuf_pkg
// Desc     : Shared types and constants for the 3DES output buffer arbiter.
// Revision : 1.0 - initial release
//============================================================================
package desbuf_pkg;

  // Per-cycle owner of the single SRAM address port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_t;

  // Deepest SRAM read latency the return pipe is built to track.
  localparam int DESBUF_MAX_RD_LATENCY = 3;

endpackage : desbuf_pkg
`default_nettype wire

// File: rtl/desbuf_rd_pipe.sv
`default_nettype none
//============================================================================
// Module   : desbuf_rd_pipe
// Desc     : Valid-token shift register that tracks issued SRAM reads until
//            their data is due on sram_q. A synchronous kill drops every
//            token in flight.
// Revision : 1.0 - initial release
//============================================================================
module desbuf_rd_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kill,
  input  logic in_valid,
  output logic out_valid
);
  import desbuf_pkg::*;

  // Depth is clamped to the supported range so a bad override still builds.
  localparam int c_pipe_depth = (LATENCY < 1) ? 1 :
                                (LATENCY > DESBUF_MAX_RD_LATENCY) ? DESBUF_MAX_RD_LATENCY :
                                LATENCY;

  logic [c_pipe_depth-1:0] r_stage;

  generate
    if (c_pipe_depth == 1) begin : g_single
      // Single stage: capture the token, or drop it on kill.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= '0;
        end else if (kill) begin
          r_stage <= '0;
        end else begin
          r_stage <= in_valid;
        end
      end
    end else begin : g_shift
      // Multi stage: shift tokens toward the output, clear all on kill.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= '0;
        end else if (kill) begin
          r_stage <= '0;
        end else begin
          r_stage <= {r_stage[c_pipe_depth-2:0], in_valid};
        end
      end
    end
  endgenerate

  assign out_valid = r_stage[c_pipe_depth-1];

endmodule : desbuf_rd_pipe
`default_nettype wire

// File: rtl/des_buffer_arbiter.sv
`default_nettype none
//============================================================================
// Module   : des_buffer_arbiter
// Desc     : Ring-buffer controller for the single-port 3DES ciphertext
//            SRAM. Arbitrates each cycle between the DES output stream
//            (writer) and the host CSR drain (reader), round-robin when both
//            are eligible, and tracks pointers, occupancy and status flags.
//            Optional macro DESBUF_WATERMARK_EN enables the sticky level_irq.
// Revision : 1.0 - initial release
//============================================================================
module des_buffer_arbiter #(
  parameter int ADDRSIZE     = 14,
  parameter int SRAMWIDTH    = 64,
  parameter int RD_LATENCY   = 1,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 wr_valid,
  input  logic [SRAMWIDTH-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 rd_req,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [SRAMWIDTH-1:0] rd_data,
  output logic [ADDRSIZE-1:0]  sram_addr,
  output logic [SRAMWIDTH-1:0] sram_wdata,
  output logic                 sram_we,
  output logic                 sram_re,
  input  logic [SRAMWIDTH-1:0] sram_q,
  output logic [ADDRSIZE:0]    count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  input  logic [ADDRSIZE:0]    watermark,
  input  logic                 irq_clr,
  output logic                 level_irq
);
  import desbuf_pkg::*;

  localparam int c_depth_i = 2 ** ADDRSIZE;
  localparam int c_afull_i = c_depth_i - AFULL_MARGIN;
  localparam logic [ADDRSIZE:0]   c_depth   = c_depth_i[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0]   c_afull   = c_afull_i[ADDRSIZE:0];
  localparam logic [ADDRSIZE-1:0] c_ptr_one = {{(ADDRSIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0]   c_cnt_one = {{ADDRSIZE{1'b0}}, 1'b1};

  logic [ADDRSIZE-1:0]  r_wr_ptr;
  logic [ADDRSIZE-1:0]  r_rd_ptr;
  logic [ADDRSIZE-1:0]  r_addr_hold;
  logic [ADDRSIZE:0]    r_count;
  logic [ADDRSIZE:0]    w_count_nxt;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_afull;
  grant_t               r_last_grant;
  grant_t               w_grant;
  logic                 w_wr_elig;
  logic                 w_rd_elig;
  logic                 w_pipe_out;
  logic                 r_rd_valid;
  logic [SRAMWIDTH-1:0] r_rd_data;

  assign w_wr_elig = wr_valid && !r_full;
  assign w_rd_elig = rd_req && !r_empty;

  // Pick one port owner per cycle; flush and reset suppress every grant.
  always_comb begin
    w_grant = GNT_NONE;
    if (reset_n && !flush) begin
      if (w_wr_elig && w_rd_elig) begin
        w_grant = (r_last_grant == GNT_WR) ? GNT_RD : GNT_WR;
      end else if (w_wr_elig) begin
        w_grant = GNT_WR;
      end else if (w_rd_elig) begin
        w_grant = GNT_RD;
      end
    end
  end

  // Drive the SRAM port and handshakes straight from the grant.
  always_comb begin
    wr_ready    = 1'b0;
    rd_ack      = 1'b0;
    sram_we     = 1'b0;
    sram_re     = 1'b0;
    sram_addr   = r_addr_hold;
    w_count_nxt = r_count;
    case (w_grant)
      GNT_WR: begin
        wr_ready    = 1'b1;
        sram_we     = 1'b1;
        sram_addr   = r_wr_ptr;
        w_count_nxt = r_count + c_cnt_one;
      end
      GNT_RD: begin
        rd_ack      = 1'b1;
        sram_re     = 1'b1;
        sram_addr   = r_rd_ptr;
        w_count_nxt = r_count - c_cnt_one;
      end
      default: ;
    endcase
  end

  assign sram_wdata = wr_data;

  // Pointers, occupancy, status flags and arbitration history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_addr_hold  <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_last_grant <= GNT_RD;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_grant == GNT_WR) begin
        r_wr_ptr     <= r_wr_ptr + c_ptr_one;
        r_addr_hold  <= r_wr_ptr;
        r_last_grant <= GNT_WR;
      end else if (w_grant == GNT_RD) begin
        r_rd_ptr     <= r_rd_ptr + c_ptr_one;
        r_addr_hold  <= r_rd_ptr;
        r_last_grant <= GNT_RD;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
      r_afull <= (w_count_nxt >= c_afull);
    end
  end

  desbuf_rd_pipe #(
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill      (flush),
    .in_valid  (w_grant == GNT_RD),
    .out_valid (w_pipe_out)
  );

  // Capture returning SRAM data when its token leaves the pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_pipe_out && !flush;
      if (w_pipe_out && !flush) begin
        r_rd_data <= sram_q;
      end
    end
  end

`ifdef DESBUF_WATERMARK_EN
  logic r_level_irq;

  // Sticky level flag; a set condition outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level_irq <= 1'b0;
    end else if ((watermark != '0) && (r_count >= watermark)) begin
      r_level_irq <= 1'b1;
    end else if (irq_clr) begin
      r_level_irq <= 1'b0;
    end
  end

  assign level_irq = r_level_irq;
`else
  logic w_unused_wm;
  assign w_unused_wm = ^{watermark, irq_clr};
  assign level_irq   = 1'b0;
`endif

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;

endmodule : des_buffer_arbiter
`default_nettype wire

// File: tb/tb_des_buffer_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_des_buffer_arbiter
// Desc     : Directed self-checking bench for des_buffer_arbiter with a
//            depth-8 buffer and a 2-cycle SRAM model.
// Revision : 1.0 - initial release
//============================================================================
module tb_des_buffer_arbiter;

  localparam int ADDRSIZE     = 3;
  localparam int SRAMWIDTH    = 64;
  localparam int RD_LATENCY   = 2;
  localparam int AFULL_MARGIN = 4;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 wr_valid;
  logic [SRAMWIDTH-1:0] wr_data;
  logic                 wr_ready;
  logic                 rd_req;
  logic                 rd_ack;
  logic                 rd_valid;
  logic [SRAMWIDTH-1:0] rd_data;
  logic [ADDRSIZE-1:0]  sram_addr;
  logic [SRAMWIDTH-1:0] sram_wdata;
  logic                 sram_we;
  logic                 sram_re;
  logic [SRAMWIDTH-1:0] sram_q;
  logic [ADDRSIZE:0]    count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [ADDRSIZE:0]    watermark;
  logic                 irq_clr;
  logic                 level_irq;

  int vectors     = 0;
  int miscompares = 0;

  des_buffer_arbiter #(
    .ADDRSIZE     (ADDRSIZE),
    .SRAMWIDTH    (SRAMWIDTH),
    .RD_LATENCY   (RD_LATENCY),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_we     (sram_we),
    .sram_re     (sram_re),
    .sram_q      (sram_q),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .watermark   (watermark),
    .irq_clr     (irq_clr),
    .level_irq   (level_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write at the edge, read data on sram_q two cycles after sram_re.
  logic [SRAMWIDTH-1:0] mem [8];
  logic [SRAMWIDTH-1:0] rd_stage;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) rd_stage <= mem[sram_addr];
    sram_q <= rd_stage;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_data = 64'hDEAD;
    rd_req = 1'b0; irq_clr = 1'b0; watermark = '0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({wr_ready, sram_we, rd_ack} !== 3'b000) begin
      miscompares++; $display("FAIL reset_grant: got %b want 000", {wr_ready, sram_we, rd_ack});
    end
    vectors++;
    if ({count, full, empty, almost_full} !== {4'd0, 3'b010}) begin
      miscompares++; $display("FAIL reset_status: count %0d f/e/af %b want 0 010", count, {full, empty, almost_full});
    end
    vectors++;
    if ({rd_valid, rd_data, level_irq} !== {1'b0, 64'd0, 1'b0}) begin
      miscompares++; $display("FAIL reset_rd: rd_valid %b rd_data %h irq %b want 0 0 0", rd_valid, rd_data, level_irq);
    end
    wr_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    vectors++;
    if (count !== 4'd0) begin
      miscompares++; $display("FAIL reset_release_count: got %0d want 0", count);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 64'(i + 1);
      #1;
      vectors++;
      if ({wr_ready, sram_we, sram_re, sram_addr} !== {3'b110, 3'(i)}) begin
        miscompares++; $display("FAIL fill_grant[%0d]: got %b want %b", i, {wr_ready, sram_we, sram_re, sram_addr}, {3'b110, 3'(i)});
      end
      vectors++;
      if ({count, almost_full} !== {4'(i), (i >= 4)}) begin
        miscompares++; $display("FAIL fill_count[%0d]: count %0d af %b want %0d %b", i, count, almost_full, i, (i >= 4));
      end
      tick();
    end
    wr_data = 64'h9;
    #1;
    vectors++;
    if ({wr_ready, sram_we} !== 2'b00) begin
      miscompares++; $display("FAIL fill_blocked: got %b want 00", {wr_ready, sram_we});
    end
    vectors++;
    if ({count, full, empty, almost_full} !== {4'd8, 3'b101}) begin
      miscompares++; $display("FAIL fill_full: count %0d f/e/af %b want 8 101", count, {full, empty, almost_full});
    end
    tick();
    wr_valid = 1'b0;
    vectors++;
    if ({count, level_irq} !== {4'd8, 1'b0}) begin
      miscompares++; $display("FAIL fill_hold: count %0d irq %b want 8 0", count, level_irq);
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 12; c++) begin
      rd_req = (c < 8);
      #1;
      vectors++;
      if (rd_ack !== (c < 8)) begin
        miscompares++; $display("FAIL drain_ack[%0d]: got %b want %b", c, rd_ack, (c < 8));
      end
      if (c < 8) begin
        vectors++;
        if ({sram_re, sram_addr} !== {1'b1, 3'(c)}) begin
          miscompares++; $display("FAIL drain_addr[%0d]: got %b want %b", c, {sram_re, sram_addr}, {1'b1, 3'(c)});
        end
      end
      vectors++;
      if (rd_valid !== (c >= 3 && c <= 10)) begin
        miscompares++; $display("FAIL drain_valid[%0d]: got %b want %b", c, rd_valid, (c >= 3 && c <= 10));
      end
      if (c >= 3 && c <= 10) begin
        vectors++;
        if (rd_data !== 64'(c - 2)) begin
          miscompares++; $display("FAIL drain_data[%0d]: got %h want %h", c, rd_data, 64'(c - 2));
        end
      end
      vectors++;
      if (count !== 4'((c < 8) ? 8 - c : 0)) begin
        miscompares++; $display("FAIL drain_count[%0d]: got %0d want %0d", c, count, (c < 8) ? 8 - c : 0);
      end
      tick();
    end
    vectors++;
    if ({full, empty} !== 2'b01) begin
      miscompares++; $display("FAIL drain_empty: f/e %b want 01", {full, empty});
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 64'(8'h11 + i);
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    #1;
    vectors++;
    if (count !== 4'd4) begin
      miscompares++; $display("FAIL rr_setup: count %0d want 4", count);
    end
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1; rd_req = 1'b1; wr_data = 64'(8'h16 + c);
      #1;
      vectors++;
      if ({wr_ready, rd_ack} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL rr_grant[%0d]: wr/rd %b want %b", c, {wr_ready, rd_ack}, (c % 2 == 0) ? 2'b10 : 2'b01);
      end
      vectors++;
      if (count !== ((c % 2 == 0) ? 4'd4 : 4'd5)) begin
        miscompares++; $display("FAIL rr_count[%0d]: got %0d want %0d", c, count, (c % 2 == 0) ? 4 : 5);
      end
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    repeat (4) tick();
    flush = 1'b1; wr_valid = 1'b1; rd_req = 1'b1;
    #1;
    vectors++;
    if ({wr_ready, rd_ack, sram_we, sram_re} !== 4'b0000) begin
      miscompares++; $display("FAIL rr_flush_grant: got %b want 0000", {wr_ready, rd_ack, sram_we, sram_re});
    end
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    #1;
    vectors++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      miscompares++; $display("FAIL rr_flush_state: count %0d empty %b want 0 1", count, empty);
    end
  endtask

  task automatic test_wrap();
    bit is_wr [24] = '{1,1,1,1,1,1, 0,0,0, 1,1,1,1,1, 0,0,0,0, 1, 0,0,0,0,0};
    int wi = 0;
    int ri = 0;
    int exp_rd = 1;
    for (int s = 0; s < 30; s++) begin
      if (s < 24) begin
        wr_valid = is_wr[s]; rd_req = !is_wr[s]; wr_data = 64'(wi + 1);
      end else begin
        wr_valid = 1'b0; rd_req = 1'b0;
      end
      #1;
      if (s == 14) begin
        vectors++;
        if ({count, full} !== {4'd8, 1'b1}) begin
          miscompares++; $display("FAIL wrap_full: count %0d full %b want 8 1", count, full);
        end
      end
      if (s < 24 && is_wr[s]) begin
        vectors++;
        if ({wr_ready, sram_we, sram_addr} !== {2'b11, 3'(wi % 8)}) begin
          miscompares++; $display("FAIL wrap_wr[%0d]: got %b want %b", s, {wr_ready, sram_we, sram_addr}, {2'b11, 3'(wi % 8)});
        end
        wi++;
      end else if (s < 24) begin
        vectors++;
        if ({rd_ack, sram_re, sram_addr} !== {2'b11, 3'(ri % 8)}) begin
          miscompares++; $display("FAIL wrap_rd[%0d]: got %b want %b", s, {rd_ack, sram_re, sram_addr}, {2'b11, 3'(ri % 8)});
        end
        ri++;
      end
      if (rd_valid) begin
        vectors++;
        if (rd_data !== 64'(exp_rd)) begin
          miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", s, rd_data, 64'(exp_rd));
        end
        exp_rd++;
      end
      tick();
    end
    vectors++;
    if (exp_rd !== 13) begin
      miscompares++; $display("FAIL wrap_returns: got %0d words want 12", exp_rd - 1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 64'(8'h21 + i);
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b1;
    #1;
    vectors++;
    if (rd_ack !== 1'b1) begin
      miscompares++; $display("FAIL flush_ack: got %b want 1", rd_ack);
    end
    tick();
    rd_req = 1'b0; flush = 1'b1; wr_valid = 1'b1;
    #1;
    vectors++;
    if ({wr_ready, rd_ack} !== 2'b00) begin
      miscompares++; $display("FAIL flush_prio: got %b want 00", {wr_ready, rd_ack});
    end
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    #1;
    vectors++;
    if ({count, empty, full} !== {4'd0, 2'b10}) begin
      miscompares++; $display("FAIL flush_state: count %0d e/f %b want 0 10", count, {empty, full});
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (rd_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_kill[%0d]: rd_valid %b want 0", c, rd_valid);
      end
      tick();
    end
    wr_valid = 1'b1; wr_data = 64'h31;
    #1;
    vectors++;
    if ({wr_ready, sram_addr} !== {1'b1, 3'd0}) begin
      miscompares++; $display("FAIL flush_ptr: got %b want 1000", {wr_ready, sram_addr});
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_watermark();
    flush = 1'b1;
    tick();
    flush = 1'b0; watermark = 4'd5;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 64'(8'h41 + i);
      #1;
      if (i == 4) begin
        vectors++;
        if (level_irq !== 1'b0) begin
          miscompares++; $display("FAIL wm_early: got %b want 0", level_irq);
        end
      end
      tick();
    end
    wr_valid = 1'b0;
    tick();
    vectors++;
`ifdef DESBUF_WATERMARK_EN
    if (level_irq !== 1'b1) begin
      miscompares++; $display("FAIL wm_set: got %b want 1", level_irq);
    end
`else
    if (level_irq !== 1'b0) begin
      miscompares++; $display("FAIL wm_off: got %b want 0", level_irq);
    end
`endif
    rd_req = 1'b1;
    repeat (2) tick();
    rd_req = 1'b0;
    repeat (4) tick();
    vectors++;
`ifdef DESBUF_WATERMARK_EN
    if ({count, level_irq} !== {4'd3, 1'b1}) begin
      miscompares++; $display("FAIL wm_sticky: count %0d irq %b want 3 1", count, level_irq);
    end
`else
    if ({count, level_irq} !== {4'd3, 1'b0}) begin
      miscompares++; $display("FAIL wm_sticky: count %0d irq %b want 3 0", count, level_irq);
    end
`endif
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    #1;
    vectors++;
    if (level_irq !== 1'b0) begin
      miscompares++; $display("FAIL wm_clr: got %b want 0", level_irq);
    end
    watermark = '0;
  endtask

  task automatic test_async_reset();
    wr_valid = 1'b1; wr_data = 64'h51;
    tick();
    wr_valid = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({count, empty, full, almost_full} !== {4'd0, 3'b100}) begin
      miscompares++; $display("FAIL areset_state: count %0d e/f/af %b want 0 100", count, {empty, full, almost_full});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (rd_valid !== 1'b0) begin
        miscompares++; $display("FAIL areset_kill[%0d]: rd_valid %b want 0", c, rd_valid);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_round_robin();
    test_wrap();
    test_flush();
    test_watermark();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_des_buffer_arbiter
`default_nettype wire
